// File: rtl/breath_pkg.sv
// Shared types and default constants for the LED breathing-profile sequencer.
package breath_pkg;

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } breath_state_e;

    localparam int DEF_PERIOD_CYC   = 500_000;
    localparam int DEF_STEP         = 2_500;
    localparam int DEF_HOLD_PERIODS = 20;
    localparam int DEF_DEB_CYC      = 1_000_000;
    localparam int DEF_DUTY_W       = 19;

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on the cycle before an accepted 1->0 level change takes effect.
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The counter restarts whenever the synchronized level is about to change,
    // so it only saturates once sync2 has been stable for DEB_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync1 != sync2)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX && sync2 != level)
                level <= sync2;
        end
    end

    assign press = (cnt == CNT_MAX) && level && !sync2;

endmodule

// File: rtl/breath_duty_gen.sv
// Triangular duty-ramp sequencer feeding the LED PWM compare value; advances
// once per PWM period and can be paused/resumed with a debounced push-button.
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int PERIOD_CYC   = DEF_PERIOD_CYC,
    parameter int STEP         = DEF_STEP,
    parameter int HOLD_PERIODS = DEF_HOLD_PERIODS,
    parameter int DEB_CYC      = DEF_DEB_CYC,
    parameter int DUTY_W       = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_n,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_vld,
    output logic              paused,
    output logic [1:0]        state
);

    localparam int HC_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [DUTY_W:0]   PERIOD_X  = (DUTY_W + 1)'(PERIOD_CYC);
    localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(PERIOD_CYC);
    localparam logic [DUTY_W-1:0] DUTY_STEP = DUTY_W'(STEP);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_PERIODS - 1);

    breath_state_e     state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic              vld_q, vld_d;
    logic              paused_q, paused_d;
    logic [DUTY_W:0]   sum;
    logic              press;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RISE;
            duty_q   <= '0;
            hold_q   <= '0;
            vld_q    <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            hold_q   <= hold_d;
            vld_q    <= vld_d;
            paused_q <= paused_d;
        end
    end

    // The strobe is gated by the pre-toggle paused value, so a press landing
    // on the same edge still lets that period's update through.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        hold_d   = hold_q;
        vld_d    = 1'b0;
        paused_d = paused_q ^ press;
        sum      = {1'b0, duty_q} + STEP_X;
        if (period_end && !paused_q) begin
            vld_d = 1'b1;
            unique case (state_q)
                RISE: begin
                    if (sum >= PERIOD_X) begin
                        duty_d  = DUTY_MAX;
                        state_d = HOLD_HI;
                    end else begin
                        duty_d = sum[DUTY_W-1:0];
                    end
                end
                FALL: begin
                    if (duty_q <= DUTY_STEP) begin
                        duty_d  = '0;
                        state_d = HOLD_LO;
                    end else begin
                        duty_d = duty_q - DUTY_STEP;
                    end
                end
                HOLD_HI, HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = (state_q == HOLD_HI) ? FALL : RISE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = RISE;
            endcase
        end
    end

    assign duty     = duty_q;
    assign duty_vld = vld_q;
    assign paused   = paused_q;
    assign state    = state_q;

endmodule

// File: doc/breath_duty_gen.md
# breath_duty_gen

Brightness-profile sequencer for the LED PWM stage. Produces a triangular duty ramp (rise, hold-high, fall, hold-low), updated once per PWM period on the strobe returned by the PWM stage, so the PWM compare value never changes mid-period. A debounced push-button toggles pause/run. Sits directly upstream of the single-LED PWM block and drives its high-time compare value.

## Interface
- PERIOD_CYC, 500_000: PWM period in clk cycles (10 ms at 50 MHz); maximum duty value.
- STEP, 2_500: duty increment/decrement per period; 0 < STEP <= PERIOD_CYC.
- HOLD_PERIODS, 20: periods spent in each hold state; >= 1.
- DEB_CYC, 1_000_000: key stable time for acceptance (20 ms).
- DUTY_W, 19: duty width; 2**DUTY_W > PERIOD_CYC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key_n  in  1  raw push-button, active-low, asynchronous to clk.
- period_end  in  1  one-cycle strobe from the PWM stage at the last cycle of each period.
- duty  out  DUTY_W  PWM high-time in cycles, 0..PERIOD_CYC.
- duty_vld  out  1  one-cycle pulse: duty was reloaded.
- paused  out  1  1 = sequencer frozen.
- state  out  2  current FSM state (RISE=0, HOLD_HI=1, FALL=2, HOLD_LO=3).

## Operation
- Reset values: duty=0, duty_vld=0, paused=0, state=RISE, hold count=0, debounced key level=1.
- period_end is processed only when paused=0 (pre-toggle value); each processed strobe produces exactly one duty_vld, even if duty is unchanged.
- RISE: if duty+STEP >= PERIOD_CYC then duty=PERIOD_CYC, go HOLD_HI; else duty += STEP.
- HOLD_HI: hold count +1; when it reaches HOLD_PERIODS, clear it, go FALL; duty unchanged.
- FALL: if duty <= STEP then duty=0, go HOLD_LO; else duty -= STEP.
- HOLD_LO: as HOLD_HI, exits to RISE.
- Sum duty+STEP is computed at DUTY_W+1 bits; no wrap-around.
- Debounce: 2-flop synchronizer; counter clears on any change of the synced level; level accepted when stable DEB_CYC cycles. Accepted 1->0 transition = press; press toggles paused. Release has no effect.
- Glitches shorter than DEB_CYC are rejected.
- Pause freezes duty, state and hold count; run resumes from the frozen point.

## Timing
- duty, state and duty_vld update on the clock edge after the cycle in which period_end is high (latency 1).
- duty_vld never asserts in consecutive cycles unless period_end does.
- Key held low from cycle 0: paused toggles at cycle DEB_CYC+3.
- Press and period_end in the same cycle: the strobe is handled with the old paused value, and the toggle takes effect in the same edge.
- rst_n assertion mid-operation returns all outputs to their reset values immediately (asynchronously). After release, operation restarts from RISE with duty=0.
- Full cycle at defaults: 200 rise + 20 hold + 200 fall + 20 hold periods = 4.4 s.

## Structure
- Package breath_pkg: state enum (RISE, HOLD_HI, FALL, HOLD_LO, 2-bit encoding as above), default constants for PERIOD_CYC, STEP, HOLD_PERIODS and DEB_CYC.
- One sub-module key_debounce (synchronizer, stability counter, press pulse output). The FSM and duty datapath stay in breath_duty_gen.

## Test plan
Sim params: PERIOD_CYC=100, STEP=30, HOLD_PERIODS=2, DEB_CYC=8.
- Reset release, 4 period_end pulses -> duty 30, 60, 90, 100, with duty_vld 1 cycle after each pulse; state=HOLD_HI after the 4th.
- 2 more strobes -> duty stays 100, 2 duty_vld pulses, state=FALL. Next 4 strobes -> 70, 40, 10, 0, HOLD_LO. 2 strobes -> RISE.
- key_n low 5 cycles then high -> paused stays 0. key_n low 20 cycles -> paused=1 exactly 11 cycles after the fall. Subsequent period_end -> no duty_vld, duty frozen. Second press -> paused=0, ramp resumes.
- Press acceptance coincident with period_end while running -> that strobe still updates duty (duty_vld=1) and paused=1 on the same edge.
- rst_n pulsed low during FALL at duty=40 -> duty=0, state=RISE, paused=0 immediately; the next strobe gives duty=30.
- STEP=PERIOD_CYC=100 -> the first strobe gives duty=100/HOLD_HI; in FALL, the first strobe gives duty=0/HOLD_LO.
